// File: rtl/hms_display_driver.sv
// rtl/hms_display_driver.sv - HH.MM.SS six-digit multiplexed 7-segment driver with BCD conversion
//
// Purpose: captures binary hours/minutes/seconds from another clock domain and
// accepts them once they are stable. It converts all three fields to BCD with a
// shared double-dabble sequencer, commits the six digits atomically, and scans
// them onto a common-anode display.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   h_i[4:0]     binary hours   (0..31 displayed as-is)
//   mi_i[5:0]    binary minutes (0..63 displayed as-is)
//   s_i[5:0]     binary seconds (0..63 displayed as-is)
//   blank_i      forces every digit off while high
//   an_o[5:0]    digit enables, active-low (an_o[0] = seconds ones)
//   seg_o[6:0]   segments {g,f,e,d,c,b,a}, active-low
//   dp_o         decimal point, active-low
//   conv_busy_o  high while a BCD conversion is in flight

module hms_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] h_i,
    input  logic [5:0] mi_i,
    input  logic [5:0] s_i,
    input  logic       blank_i,
    output logic [5:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic       conv_busy_o
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    // Each field register is {tens[3:0], ones[3:0], binary[5:0]}.
    function automatic logic [13:0] dabble_step(input logic [13:0] r);
        logic [13:0] t;
        t = r;
        if (t[9:6] >= 4'd5) begin
            t[9:6] = t[9:6] + 4'd3;
        end
        if (t[13:10] >= 4'd5) begin
            t[13:10] = t[13:10] + 4'd3;
        end
        return {t[12:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic [16:0]   samp_q;
    logic [16:0]   shown_q;
    logic [16:0]   conv_q;     // value being converted; becomes shown_q at commit
    logic [13:0]   dd_h_q;
    logic [13:0]   dd_m_q;
    logic [13:0]   dd_s_q;
    logic [5:0][3:0] dig_q;    // [0] = seconds ones ... [5] = hours tens
    logic          busy_q;

    logic [PW-1:0] psc_q, psc_d;
    logic [2:0]    idx_q, idx_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [16:0]   vec_in;
    logic          trigger;
    logic          psc_wrap;
    logic [3:0]    sel_dig;

    assign vec_in = {h_i, mi_i, s_i};

    // Accept a value only when it has held for a full cycle and is not already displayed.
    assign trigger = (state_q == ST_IDLE) && (samp_q == vec_in) && (samp_q != shown_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            samp_q <= '0;
        end else begin
            samp_q <= vec_in;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shown_q <= '0;
            conv_q  <= '0;
            dd_h_q  <= '0;
            dd_m_q  <= '0;
            dd_s_q  <= '0;
            dig_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        conv_q  <= samp_q;
                        dd_h_q  <= {8'd0, 1'b0, samp_q[16:12]};
                        dd_m_q  <= {8'd0, samp_q[11:6]};
                        dd_s_q  <= {8'd0, samp_q[5:0]};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The counter reaching 6 spends one extra cycle here before COMMIT.
                    if (cnt_q == 3'd6) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        dd_h_q <= dabble_step(dd_h_q);
                        dd_m_q <= dabble_step(dd_m_q);
                        dd_s_q <= dabble_step(dd_s_q);
                        cnt_q  <= cnt_q + 3'd1;
                    end
                end
                ST_COMMIT: begin
                    dig_q   <= {dd_h_q[13:10], dd_h_q[9:6],
                                dd_m_q[13:10], dd_m_q[9:6],
                                dd_s_q[13:10], dd_s_q[9:6]};
                    shown_q <= conv_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        sel_dig = 4'd0;
        case (idx_q)
            3'd0:    sel_dig = dig_q[0];
            3'd1:    sel_dig = dig_q[1];
            3'd2:    sel_dig = dig_q[2];
            3'd3:    sel_dig = dig_q[3];
            3'd4:    sel_dig = dig_q[4];
            3'd5:    sel_dig = dig_q[5];
            default: sel_dig = 4'd0;
        endcase
    end

    always_comb begin
        psc_wrap = (psc_q == PW'(REFRESH_DIV - 1));
        psc_d    = psc_wrap ? '0 : psc_q + 1'b1;
        idx_d    = idx_q;
        if (psc_wrap) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        // Outputs reflect the pre-edge index, so an/seg/dp trail idx_q by one cycle.
        if (blank_i) begin
            an_d  = 6'b111111;
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(6'b000001 << idx_q);
            seg_d = seg_decode(sel_dig);
            dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psc_q <= '0;
            idx_q <= '0;
            an_q  <= 6'b111111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            psc_q <= psc_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an_o        = an_q;
    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign conv_busy_o = busy_q;

endmodule

// File: tb/tb_hms_display_driver.sv
// tb/tb_hms_display_driver.sv - self-checking bench for hms_display_driver

module tb_hms_display_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] h = '0;
    logic [5:0] mi = '0;
    logic [5:0] s = '0;
    logic       blank = 1'b0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hms_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk_i(clk), .rst_i(rst), .h_i(h), .mi_i(mi), .s_i(s), .blank_i(blank),
        .an_o(an), .seg_o(seg), .dp_o(dp), .conv_busy_o(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Digit p of a packed {h,mi,s} time value, position 0 = seconds ones.
    function automatic int digit_of(input int v, input int p);
        int hv, mv, sv;
        hv = (v >> 12) & 31;
        mv = (v >> 6) & 63;
        sv = v & 63;
        case (p)
            0: return sv % 10;
            1: return sv / 10;
            2: return mv % 10;
            3: return mv / 10;
            4: return hv % 10;
            default: return hv / 10;
        endcase
    endfunction

    // Model: scan position from edge count since reset; conversion as a scheduled
    // commit 8 edges after an accepted stable value.
    int         e, m_samp, m_shown, m_val, m_commit, m_idx, m_in;
    bit         m_busy;
    logic [5:0] x_an = 6'h3f;
    logic [6:0] x_seg = 7'h7f;
    logic       x_dp = 1'b1;
    logic       x_busy = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                e = 0; m_samp = 0; m_shown = 0; m_val = 0; m_commit = -1; m_busy = 0;
                x_an = 6'h3f; x_seg = 7'h7f; x_dp = 1'b1; x_busy = 1'b0;
            end else begin
                m_idx = (e / DIV) % 6;
                if (blank) begin
                    x_an = 6'h3f; x_seg = 7'h7f; x_dp = 1'b1;
                end else begin
                    x_an  = ~(6'b000001 << m_idx);
                    x_seg = seg7(digit_of(m_shown, m_idx));
                    x_dp  = !((m_idx == 2) || (m_idx == 4));
                end
                m_in = int'({h, mi, s});
                if (m_busy && e == m_commit) begin
                    m_shown = m_val; m_busy = 0; x_busy = 1'b0;
                end else if (!m_busy && m_samp == m_in && m_samp != m_shown) begin
                    m_val = m_samp; m_commit = e + 8; m_busy = 1; x_busy = 1'b1;
                end
                m_samp = m_in;
                e++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_an", 32'(an), 32'(x_an));
                chk("model_seg", 32'(seg), 32'(x_seg));
                chk("model_dp", 32'(dp), 32'(x_dp));
                chk("model_busy", 32'(busy), 32'(x_busy));
            end
        end
    end

    task automatic set_in(input int hv, input int mv, input int sv);
        @(posedge clk); #2;
        h = 5'(hv); mi = 6'(mv); s = 6'(sv);
    endtask

    task automatic count_busy(input int cycles, input int exp, input string name);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b1) n++;
        end
        chk(name, 32'(n), 32'(exp));
    endtask

    // Expected segment patterns listed an[5] first, down to an[0].
    task automatic frame_check(input string name,
                               input logic [6:0] e5, input logic [6:0] e4, input logic [6:0] e3,
                               input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] got [6];
        logic [6:0] exp [6];
        logic [5:0] sel;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3; exp[4] = e4; exp[5] = e5;
        for (int p = 0; p < 6; p++) got[p] = 7'h7f;
        for (int i = 0; i < 6 * DIV + 2; i++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 6; p++) begin
                sel = ~(6'b000001 << p);
                if (an === sel) got[p] = seg;
            end
        end
        for (int p = 0; p < 6; p++) chk($sformatf("%s_digit%0d", name, p), 32'(got[p]), 32'(exp[p]));
    endtask

    initial begin
        logic [5:0] ex_an;
        int q;
        rst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Zero time: one-hot scan, each position DIV cycles, dp at positions 2 and 4.
        for (int i = 0; i < 6 * DIV; i++) begin
            @(posedge clk); #1;
            q = i / DIV;
            ex_an = ~(6'b000001 << q);
            chk("scan_an", 32'(an), 32'(ex_an));
            chk("scan_seg_zero", 32'(seg), 32'(7'b1000000));
            chk("scan_dp", 32'(dp), (q == 2 || q == 4) ? 32'd0 : 32'd1);
        end

        // 23:59:07
        set_in(23, 59, 7);
        count_busy(30, 8, "busy_len_235907");
        frame_check("t_235907", 7'b0100100, 7'b0110000, 7'b0010010,
                    7'b0010000, 7'b1000000, 7'b1111000);

        // s = 45 then s = 46 three edges after the trigger
        set_in(23, 59, 45);
        @(posedge clk);               // samp valid
        @(posedge clk); #1;           // trigger edge T
        chk("busy_at_T", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);    // T+2
        #2 s = 6'd46;
        repeat (6) @(posedge clk); #1; // T+8
        chk("busy_at_T8", 32'(busy), 32'd0);
        @(posedge clk); #1;           // T+9
        chk("busy_at_T9", 32'(busy), 32'd1);
        repeat (7) @(posedge clk); #1; // T+16
        chk("busy_at_T16", 32'(busy), 32'd1);
        @(posedge clk); #1;           // T+17
        chk("busy_at_T17", 32'(busy), 32'd0);
        frame_check("t_235946", 7'b0100100, 7'b0110000, 7'b0010010,
                    7'b0010000, 7'b0011001, 7'b0000010);

        // Maxima 31:63:63
        set_in(31, 63, 63);
        repeat (12) @(posedge clk);
        frame_check("t_max", 7'b0110000, 7'b1111001, 7'b0000010,
                    7'b0110000, 7'b0000010, 7'b0110000);

        // Reset in the middle of a conversion
        set_in(12, 34, 56);
        @(posedge clk);
        @(posedge clk);               // T
        repeat (3) @(posedge clk);    // T+3
        #2 rst = 1'b1;
        #1;
        chk("rst_an", 32'(an), 32'(6'b111111));
        chk("rst_seg", 32'(seg), 32'(7'b1111111));
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_an", 32'(an), 32'(6'b111110));
        chk("post_rst_seg", 32'(seg), 32'(7'b1000000));
        repeat (12) @(posedge clk);
        frame_check("t_123456", 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010);

        // Blank for 10 cycles
        @(posedge clk); #2 blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("blank_an", 32'(an), 32'(6'b111111));
            chk("blank_seg", 32'(seg), 32'(7'b1111111));
        end
        #1 blank = 1'b0;
        repeat (3 * 6 * DIV) @(posedge clk);

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
